tmr_seq_ctrl: RTL and testbench

TMR_SEQ_CTRL -- requirements
Module: tmr_seq_ctrl

---
 rtl/tmr_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_tmr_seq_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_seq_ctrl.sv
// Sequencer for a TMR calculator: capture, wait LATENCY, vote-check, retry via resync; result strobe LATENCY+3 cycles after start.
// No backpressure: start is taken only while ready=1 (never queued), and results are one-cycle strobes with no stall path.
module tmr_seq_ctrl #(
    parameter int LATENCY    = 2,
    parameter int MAX_RETRY  = 2,
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    ready,
    output logic                    capture_en,
    output logic                    calc_rst,
    input  logic signed [15:0]      psi_in,
    input  logic signed [15:0]      theta_in,
    input  logic                    mismatch_in,
    input  logic                    uncor_in,
    output logic signed [15:0]      omega_psi,
    output logic signed [15:0]      omega_theta,
    output logic                    out_valid,
    output logic                    out_error,
    output logic                    fault_sticky,
    output logic [CNT_W-1:0]        corr_cnt,
    output logic [CNT_W-1:0]        uncor_cnt,
    input  logic                    clr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_WAIT,
        S_CHECK,
        S_RESYNC
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] wait_cnt;
    logic [2:0] retry_cnt;
    logic       in_check;
    logic       exhausted;
    logic       deliver;
    logic       corr_inc;
    logic       uncor_inc;

    assign in_check  = (state_q == S_CHECK);
    assign exhausted = (retry_cnt == 3'(MAX_RETRY));
    assign deliver   = in_check && (!uncor_in || exhausted);
    assign corr_inc  = in_check && !uncor_in && mismatch_in;
    assign uncor_inc = in_check && uncor_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Leaving RESYNC with retry_cnt=0 means the retry budget was spent
    // (the exhaustion path clears it); any live retry has retry_cnt>=1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_WAIT;
            S_WAIT:    if (wait_cnt == 4'd1) state_d = S_CHECK;
            S_CHECK:   state_d = uncor_in ? S_RESYNC : S_IDLE;
            S_RESYNC:  if (wait_cnt == 4'd1) state_d = (retry_cnt == 3'd0) ? S_IDLE : S_CAPTURE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready      = 1'b0;
        capture_en = 1'b0;
        calc_rst   = 1'b0;
        case (state_q)
            S_IDLE:    ready      = 1'b1;
            S_CAPTURE: capture_en = 1'b1;
            S_RESYNC:  calc_rst   = 1'b1;
            default:   ;
        endcase
    end

    // One down-counter times both the calculator latency and the resync pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 4'd0;
        end else begin
            case (state_q)
                S_CAPTURE: wait_cnt <= 4'(LATENCY);
                S_CHECK:   wait_cnt <= 4'(RST_CYCLES);
                S_WAIT, S_RESYNC: if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                default:   wait_cnt <= wait_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retry_cnt <= 3'd0;
        end else if (in_check) begin
            if (!uncor_in || exhausted) begin
                retry_cnt <= 3'd0;
            end else begin
                retry_cnt <= retry_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_error   <= 1'b0;
            omega_psi   <= '0;
            omega_theta <= '0;
        end else begin
            out_valid <= deliver;
            out_error <= deliver && uncor_in;
            if (deliver) begin
                omega_psi   <= psi_in;
                omega_theta <= theta_in;
            end
        end
    end

    // clr_cnt takes priority over any same-cycle increment or fault set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            corr_cnt     <= '0;
            uncor_cnt    <= '0;
            fault_sticky <= 1'b0;
        end else if (clr_cnt) begin
            corr_cnt     <= '0;
            uncor_cnt    <= '0;
            fault_sticky <= 1'b0;
        end else begin
            if (corr_inc && (corr_cnt != '1)) begin
                corr_cnt <= corr_cnt + 1'b1;
            end
            if (uncor_inc && (uncor_cnt != '1)) begin
                uncor_cnt <= uncor_cnt + 1'b1;
            end
            if (uncor_inc && exhausted) begin
                fault_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tmr_seq_ctrl.sv
// Bench for tmr_seq_ctrl: a timeline model plans every accepted run into per-cycle expectations,
// then one loop drives the stimulus and compares every output each cycle.
module tb_tmr_seq_ctrl;
    localparam int LAT = 2;
    localparam int MR  = 2;
    localparam int RC  = 4;
    localparam int CW  = 2;
    localparam int N   = 160;

    logic                clk;
    logic                rst;
    logic                start;
    logic                ready;
    logic                capture_en;
    logic                calc_rst;
    logic signed [15:0]  psi_in;
    logic signed [15:0]  theta_in;
    logic                mismatch_in;
    logic                uncor_in;
    logic signed [15:0]  omega_psi;
    logic signed [15:0]  omega_theta;
    logic                out_valid;
    logic                out_error;
    logic                fault_sticky;
    logic [CW-1:0]       corr_cnt;
    logic [CW-1:0]       uncor_cnt;
    logic                clr_cnt;

    tmr_seq_ctrl #(
        .LATENCY    (LAT),
        .MAX_RETRY  (MR),
        .RST_CYCLES (RC),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .ready        (ready),
        .capture_en   (capture_en),
        .calc_rst     (calc_rst),
        .psi_in       (psi_in),
        .theta_in     (theta_in),
        .mismatch_in  (mismatch_in),
        .uncor_in     (uncor_in),
        .omega_psi    (omega_psi),
        .omega_theta  (omega_theta),
        .out_valid    (out_valid),
        .out_error    (out_error),
        .fault_sticky (fault_sticky),
        .corr_cnt     (corr_cnt),
        .uncor_cnt    (uncor_cnt),
        .clr_cnt      (clr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs per cycle and the stimulus that goes with them.
    bit e_cap[N], e_crst[N], e_busy[N], e_vld[N], e_err[N];
    int e_psi[N], e_th[N];
    bit d_check[N], d_mism[N], d_unc[N], d_start[N], d_clr[N], d_rst[N];
    int d_psi[N], d_th[N];
    bit inc_corr[N], inc_unc[N], set_flt[N];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int k, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d", nm, k, act, exp);
    endtask

    // One accepted start at cycle c0; mask bit a = uncorrectable flag seen at attempt a.
    task automatic plan(input int c0, input int psi, input int th, input bit mism,
                        input bit [7:0] mask, output int idle_at);
        int  t;
        int  ck;
        bit  done;
        t = c0;
        done = 0;
        idle_at = c0 + 1;
        d_start[c0] = 1;
        for (int a = 0; a <= MR; a++) begin
            if (!done) begin
                e_cap[t + 1] = 1;
                ck = t + LAT + 2;
                for (int k = t + 1; k <= ck; k++) e_busy[k] = 1;
                d_check[ck] = 1;
                d_psi[ck]   = psi;
                d_th[ck]    = th;
                d_mism[ck]  = mism;
                d_unc[ck]   = mask[a];
                if (!mask[a]) begin
                    e_vld[ck + 1] = 1;
                    e_psi[ck + 1] = psi;
                    e_th[ck + 1]  = th;
                    inc_corr[ck]  = mism;
                    idle_at = ck + 1;
                    done = 1;
                end else begin
                    inc_unc[ck] = 1;
                    for (int k = ck + 1; k <= ck + RC; k++) begin
                        e_crst[k] = 1;
                        e_busy[k] = 1;
                    end
                    if (a == MR) begin
                        e_vld[ck + 1] = 1;
                        e_err[ck + 1] = 1;
                        e_psi[ck + 1] = psi;
                        e_th[ck + 1]  = th;
                        set_flt[ck]   = 1;
                        idle_at = ck + RC + 1;
                        done = 1;
                    end
                    t = ck + RC;
                end
            end
        end
    endtask

    // Reset from cycle r for len cycles aborts everything planned from r on.
    task automatic reset_at(input int r, input int len);
        for (int k = r; k < N; k++) begin
            e_cap[k] = 0; e_crst[k] = 0; e_busy[k] = 0; e_vld[k] = 0; e_err[k] = 0;
            d_check[k] = 0; inc_corr[k] = 0; inc_unc[k] = 0; set_flt[k] = 0;
        end
        for (int k = r; k < r + len; k++) d_rst[k] = 1;
    endtask

    initial begin
        int c;
        int c0;
        int total;
        int m_corr;
        int m_unc;
        int m_flt;
        int m_psi;
        int m_th;
        int sat;
        int crst_run;
        int n_vld;

        rst = 1'b1; start = 0; clr_cnt = 0;
        psi_in = '0; theta_in = '0; mismatch_in = 0; uncor_in = 0;
        #1 rst = 1'b0;

        d_rst[0] = 1; d_rst[1] = 1;
        c = 2;
        plan(c, 16'sh0123, -5, 0, 8'b000, c);             // clean, valid at 7
        plan(c, 16'sh0456, 16'sh0010, 1, 8'b000, c);      // corrected, valid at 12
        plan(c, 32767, -32768, 0, 8'b001, c);             // one retry, valid at 25
        d_clr[c] = 1; c++;
        plan(c, -1, 100, 1, 8'b111, c);                   // exhaustion, valid+err at 47
        d_clr[c] = 1; c++;
        repeat (5) plan(c, c * 3, -c, 1, 8'b000, c);      // saturate corr_cnt
        c0 = c;
        plan(c, 77, -77, 1, 8'b000, c);
        d_clr[c0 + 4] = 1;                                // clear beats increment
        c0 = c;
        plan(c, 16'sh1111, 16'sh2222, 0, 8'b111, c);
        d_clr[c0 + 4] = 1;
        d_clr[c0 + 20] = 1;                               // clear beats fault set
        plan(c, 16'sh0abc, -16'sh0abc, 1, 8'b000, c);
        c0 = c;
        plan(c, 16'sh5555, 16'sh6666, 0, 8'b000, c);
        reset_at(c0 + 2, 2);                              // reset in WAIT
        c = c0 + 4;
        c0 = c;
        plan(c, 16'sh0321, -16'sh0321, 0, 8'b000, c);     // start in reset-release cycle
        for (int k = c0 + 1; k <= c0 + 4; k++) d_start[k] = 1;
        c0 = c;
        plan(c, 16'sh0f0f, 1, 0, 8'b001, c);
        reset_at(c0 + 6, 1);                              // reset in RESYNC
        c = c0 + 7;
        total = c + 6;

        m_corr = 0; m_unc = 0; m_flt = 0; m_psi = 0; m_th = 0;
        sat = (1 << CW) - 1;
        crst_run = 0;
        n_vld = 0;

        for (int k = 0; k < total; k++) begin
            @(posedge clk);
            if (k > 0 && !d_rst[k - 1]) begin
                if (d_clr[k - 1]) begin
                    m_corr = 0; m_unc = 0; m_flt = 0;
                end else begin
                    if (inc_corr[k - 1] && m_corr < sat) m_corr++;
                    if (inc_unc[k - 1] && m_unc < sat) m_unc++;
                    if (set_flt[k - 1]) m_flt = 1;
                end
                if (e_vld[k]) begin
                    m_psi = e_psi[k];
                    m_th  = e_th[k];
                end
            end
            #1;
            rst     = !d_rst[k];
            start   = d_start[k];
            clr_cnt = d_clr[k];
            if (d_check[k]) begin
                psi_in      = 16'(d_psi[k]);
                theta_in    = 16'(d_th[k]);
                mismatch_in = d_mism[k];
                uncor_in    = d_unc[k];
            end else begin
                psi_in      = 16'($urandom);
                theta_in    = 16'($urandom);
                mismatch_in = 1'($urandom_range(0, 1));
                uncor_in    = 1'($urandom_range(0, 1));
            end
            if (d_rst[k]) begin
                m_corr = 0; m_unc = 0; m_flt = 0; m_psi = 0; m_th = 0;
            end
            @(negedge clk);
            chk("ready",        k, ready,        !e_busy[k]);
            chk("capture_en",   k, capture_en,   e_cap[k]);
            chk("calc_rst",     k, calc_rst,     e_crst[k]);
            chk("out_valid",    k, out_valid,    e_vld[k]);
            chk("out_error",    k, out_error,    e_err[k]);
            chk("omega_psi",    k, omega_psi,    m_psi);
            chk("omega_theta",  k, omega_theta,  m_th);
            chk("fault_sticky", k, fault_sticky, m_flt);
            chk("corr_cnt",     k, corr_cnt,     m_corr);
            chk("uncor_cnt",    k, uncor_cnt,    m_unc);

            n_vld += int'(out_valid);
            if (k >= 12 && k <= 24) crst_run += int'(calc_rst);
            // Hand-computed anchors for the model itself.
            if (k == 7) begin
                chk("lit_clean_valid", k, out_valid, 1);
                chk("lit_clean_psi",   k, omega_psi, 291);
                chk("lit_clean_theta", k, omega_theta, -5);
                chk("lit_clean_err",   k, out_error, 0);
            end
            if (k == 12) chk("lit_corr_cnt", k, corr_cnt, 1);
            if (k == 21) chk("lit_second_capture", k, capture_en, 1);
            if (k == 25) begin
                chk("lit_retry_rst_len", k, crst_run, 4);
                chk("lit_retry_valid",   k, out_valid, 1);
                chk("lit_retry_err",     k, out_error, 0);
                chk("lit_retry_uncor",   k, uncor_cnt, 1);
            end
            if (k == 47) begin
                chk("lit_exh_valid", k, out_valid, 1);
                chk("lit_exh_err",   k, out_error, 1);
            end
            if (k == 48) begin
                chk("lit_exh_fault", k, fault_sticky, 1);
                chk("lit_exh_uncor", k, uncor_cnt, 3);
            end
            if (k == 51) chk("lit_exh_ready", k, ready, 1);
            if (k == 77) chk("lit_sat_corr", k, corr_cnt, 3);
            if (k == 82) chk("lit_clr_wins", k, corr_cnt, 0);
            if (k == 103) begin
                chk("lit_clr_fault_wins", k, fault_sticky, 0);
                chk("lit_exh2_err",       k, out_error, 1);
            end
            if (k == 114) begin
                chk("lit_rst_ready", k, ready, 1);
                chk("lit_rst_psi",   k, omega_psi, 0);
                chk("lit_rst_corr",  k, corr_cnt, 0);
            end
            if (k == 127) chk("lit_rst_calc_rst", k, calc_rst, 0);
        end
        chk("lit_total_valids", total, n_vld, 13);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
